// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcode and funct3 codes plus the OP-IMM sequencer state encoding.
package rv32i_pkg;

   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_OP     = 7'h33;

   localparam logic [2:0] F3_ADDI  = 3'h0;
   localparam logic [2:0] F3_SLLI  = 3'h1;
   localparam logic [2:0] F3_SLTI  = 3'h2;
   localparam logic [2:0] F3_SLTIU = 3'h3;
   localparam logic [2:0] F3_XORI  = 3'h4;
   localparam logic [2:0] F3_SRXI  = 3'h5;
   localparam logic [2:0] F3_ORI   = 3'h6;
   localparam logic [2:0] F3_ANDI  = 3'h7;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RDRS   = 3'd1,
      EXEC   = 3'd2,
      WB     = 3'd3,
      RETIRE = 3'd4
   } ctrl_state_t;

endpackage

// File: rtl/ins_exec_rv32i_i_ctrl.sv
// OP-IMM sequencer: accept, read rs1, strobe the compute unit, arbitrate for the
// regfile write port, retire. Handshake: an instruction transfers on a rising edge where ins_valid && ins_ready.
module ins_exec_rv32i_i_ctrl
   import rv32i_pkg::*;
#(
   parameter int         XLEN    = 32,
   parameter logic [6:0] OPC_IMM = OPC_OP_IMM
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ins_valid,
   output logic            ins_ready,
   input  logic [6:0]      ins_dec_op,
   input  logic [2:0]      ins_dec_funct3,
   input  logic [4:0]      ins_rs1,
   input  logic [4:0]      ins_rd,
   input  logic [XLEN-1:0] ins_imm,
   output logic [4:0]      reg_r_idx,
   input  logic [XLEN-1:0] reg_r_val,
   output logic            unit_op,
   output logic [2:0]      unit_funct3,
   output logic [XLEN-1:0] unit_rs1_val,
   output logic [XLEN-1:0] unit_imm,
   output logic [4:0]      unit_rd,
   input  logic            unit_w_op,
   input  logic [4:0]      unit_w_idx,
   input  logic [XLEN-1:0] unit_w_val,
   output logic            wb_req,
   input  logic            wb_gnt,
   output logic            reg_w_op,
   output logic [4:0]      reg_w_reg_idx,
   output logic [XLEN-1:0] reg_w_reg_val,
   output logic            ins_done,
   output logic            ins_illegal,
   output logic [31:0]     instret,
   output ctrl_state_t     dbg_state
);

   ctrl_state_t     state;
   logic [4:0]      res_idx;
   logic [XLEN-1:0] res_val;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         ins_ready    <= 1'b1;
         reg_r_idx    <= '0;
         unit_op      <= 1'b0;
         unit_funct3  <= '0;
         unit_rs1_val <= '0;
         unit_imm     <= '0;
         unit_rd      <= '0;
         wb_req       <= 1'b0;
         res_idx      <= '0;
         res_val      <= '0;
         ins_done     <= 1'b0;
         ins_illegal  <= 1'b0;
         instret      <= '0;
      end else begin
         unit_op     <= 1'b0;
         ins_done    <= 1'b0;
         ins_illegal <= 1'b0;
         case (state)
            IDLE: begin
               if (ins_valid) begin
                  if (ins_dec_op == OPC_IMM) begin
                     unit_funct3 <= ins_dec_funct3;
                     unit_rd     <= ins_rd;
                     unit_imm    <= ins_imm;
                     reg_r_idx   <= ins_rs1;
                     ins_ready   <= 1'b0;
                     state       <= RDRS;
                  end else begin
                     ins_illegal <= 1'b1;
                  end
               end
            end
            RDRS: begin
               // x0 is hardwired to zero whatever the regfile returns
               unit_rs1_val <= (reg_r_idx == 5'd0) ? '0 : reg_r_val;
               unit_op      <= 1'b1;
               reg_r_idx    <= '0;
               state        <= EXEC;
            end
            EXEC: begin
               res_idx <= unit_w_idx;
               res_val <= unit_w_val;
               if (!unit_w_op) begin
                  ins_illegal <= 1'b1;
                  state       <= RETIRE;
               end else if (unit_w_idx == 5'd0) begin
                  ins_done <= 1'b1;
                  instret  <= instret + 32'd1;
                  state    <= RETIRE;
               end else begin
                  wb_req <= 1'b1;
                  state  <= WB;
               end
            end
            WB: begin
               if (wb_gnt) begin
                  wb_req   <= 1'b0;
                  ins_done <= 1'b1;
                  instret  <= instret + 32'd1;
                  state    <= RETIRE;
               end
            end
            RETIRE: begin
               ins_ready <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               ins_ready <= 1'b1;
               wb_req    <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   // Write port is only driven in the cycle the arbiter grants it.
   assign reg_w_op      = wb_req & wb_gnt;
   assign reg_w_reg_idx = res_idx;
   assign reg_w_reg_val = res_val;
   assign dbg_state     = state;

endmodule
